// File: rtl/axi4_rr_bus_arbiter_pkg.sv
// Shared AMBA4 types for the system bus: arbiter FSM states, burst/response
// encodings and the sysbus payload widths used by the external payload mux.
package sv_types_amba4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5
   } arb_state_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int CFG_SYSBUS_ADDR_BITS = 32;
   localparam int CFG_SYSBUS_DATA_BITS = 64;
   localparam int CFG_SYSBUS_STRB_BITS = CFG_SYSBUS_DATA_BITS / 8;
   localparam int CFG_SYSBUS_ID_BITS   = 5;
   localparam int CFG_SYSBUS_USER_BITS = 1;

endpackage

// File: rtl/axi4_rr_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping from NMST-1 back to 0.
module rr_pick
   import sv_types_amba4::*;
#(
   parameter int NMST     = 4,
   parameter int IDX_BITS = 2
) (
   input  logic [NMST-1:0]     i_req,
   input  logic [IDX_BITS-1:0] i_ptr,
   output logic [IDX_BITS-1:0] o_winner,
   output logic                o_any
);

   always_comb begin
      int idx;
      idx      = 0;
      o_winner = '0;
      o_any    = 1'b0;
      for (int k = 0; k < NMST; k++) begin
         idx = (int'(i_ptr) + k) % NMST;
         // Mask test instead of a variable bit-select keeps index widths exact.
         if (!o_any && ((i_req & (NMST'(1) << idx)) != '0)) begin
            o_any    = 1'b1;
            o_winner = IDX_BITS'(idx);
         end
      end
   end

endmodule

// File: rtl/axi4_rr_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4 slave port between NMST masters,
// one transaction at a time; payload is muxed externally by o_gnt_idx.
module axi4_rr_bus_arbiter
   import sv_types_amba4::*;
#(
   parameter int NMST     = 4,
   parameter int IDX_BITS = 2
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic [NMST-1:0]     i_m_arvalid,
   output logic [NMST-1:0]     o_m_arready,
   input  logic [NMST-1:0]     i_m_awvalid,
   output logic [NMST-1:0]     o_m_awready,
   input  logic [NMST-1:0]     i_m_wvalid,
   input  logic [NMST-1:0]     i_m_wlast,
   output logic [NMST-1:0]     o_m_wready,
   output logic [NMST-1:0]     o_m_rvalid,
   input  logic [NMST-1:0]     i_m_rready,
   output logic [NMST-1:0]     o_m_bvalid,
   input  logic [NMST-1:0]     i_m_bready,
   output logic                o_s_arvalid,
   input  logic                i_s_arready,
   output logic                o_s_awvalid,
   input  logic                i_s_awready,
   output logic                o_s_wvalid,
   output logic                o_s_wlast,
   input  logic                i_s_wready,
   input  logic                i_s_rvalid,
   input  logic                i_s_rlast,
   output logic                o_s_rready,
   input  logic                i_s_bvalid,
   output logic                o_s_bready,
   output logic [IDX_BITS-1:0] o_gnt_idx,
   output logic                o_busy
);

   arb_state_t          state;
   logic [IDX_BITS-1:0] gnt_idx;
   logic [IDX_BITS-1:0] rr_ptr;
   logic [IDX_BITS-1:0] winner;
   logic                any_req;
   logic [NMST-1:0]     req;
   logic [NMST-1:0]     gnt_oh;
   logic [NMST-1:0]     win_oh;
   logic                arvalid_g, awvalid_g, wvalid_g, wlast_g, rready_g, bready_g;

   assign req    = i_m_arvalid | i_m_awvalid;
   assign gnt_oh = NMST'(1) << gnt_idx;
   assign win_oh = NMST'(1) << winner;

   assign arvalid_g = |(i_m_arvalid & gnt_oh);
   assign awvalid_g = |(i_m_awvalid & gnt_oh);
   assign wvalid_g  = |(i_m_wvalid  & gnt_oh);
   assign wlast_g   = |(i_m_wlast   & gnt_oh);
   assign rready_g  = |(i_m_rready  & gnt_oh);
   assign bready_g  = |(i_m_bready  & gnt_oh);

   rr_pick #(
      .NMST     (NMST),
      .IDX_BITS (IDX_BITS)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (rr_ptr),
      .o_winner (winner),
      .o_any    (any_req)
   );

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state   <= ST_IDLE;
         gnt_idx <= '0;
         rr_ptr  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (any_req) begin
               gnt_idx <= winner;
               rr_ptr  <= (winner == IDX_BITS'(NMST - 1)) ? '0 : winner + 1'b1;
               // A master presenting both AW and AR gets its write first.
               state   <= |(i_m_awvalid & win_oh) ? ST_AW : ST_AR;
            end
            ST_AR: if (arvalid_g && i_s_arready)              state <= ST_R;
            ST_R:  if (i_s_rvalid && rready_g && i_s_rlast)   state <= ST_IDLE;
            ST_AW: if (awvalid_g && i_s_awready)              state <= ST_W;
            ST_W:  if (wvalid_g && i_s_wready && wlast_g)     state <= ST_B;
            ST_B:  if (i_s_bvalid && bready_g)                state <= ST_IDLE;
            default:                                          state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_m_arready = '0;
      o_m_awready = '0;
      o_m_wready  = '0;
      o_m_rvalid  = '0;
      o_m_bvalid  = '0;
      o_s_arvalid = 1'b0;
      o_s_awvalid = 1'b0;
      o_s_wvalid  = 1'b0;
      o_s_wlast   = 1'b0;
      o_s_rready  = 1'b0;
      o_s_bready  = 1'b0;
      case (state)
         ST_AR: begin
            o_s_arvalid = arvalid_g;
            o_m_arready = {NMST{i_s_arready}} & gnt_oh;
         end
         ST_R: begin
            o_m_rvalid = {NMST{i_s_rvalid}} & gnt_oh;
            o_s_rready = rready_g;
         end
         ST_AW: begin
            o_s_awvalid = awvalid_g;
            o_m_awready = {NMST{i_s_awready}} & gnt_oh;
         end
         ST_W: begin
            o_s_wvalid = wvalid_g;
            o_s_wlast  = wlast_g;
            o_m_wready = {NMST{i_s_wready}} & gnt_oh;
         end
         ST_B: begin
            o_m_bvalid = {NMST{i_s_bvalid}} & gnt_oh;
            o_s_bready = bready_g;
         end
         default: ;
      endcase
   end

   assign o_gnt_idx = gnt_idx;
   assign o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_axi4_rr_bus_arbiter.sv
// Directed bench for the round-robin AXI4 arbiter: reset, read/write routing,
// fairness, write-before-read priority and pointer wrap.
module tb_axi4_rr_bus_arbiter;

   logic       i_clk = 1'b0;
   logic       i_nrst;
   logic [3:0] i_m_arvalid, i_m_awvalid, i_m_wvalid, i_m_wlast, i_m_rready, i_m_bready;
   logic [3:0] o_m_arready, o_m_awready, o_m_wready, o_m_rvalid, o_m_bvalid;
   logic       o_s_arvalid, i_s_arready, o_s_awvalid, i_s_awready;
   logic       o_s_wvalid, o_s_wlast, i_s_wready;
   logic       i_s_rvalid, i_s_rlast, o_s_rready, i_s_bvalid, o_s_bready;
   logic [1:0] o_gnt_idx;
   logic       o_busy;
   logic [28:0] all_outs;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 i_clk = ~i_clk;

   assign all_outs = {o_m_arready, o_m_awready, o_m_wready, o_m_rvalid, o_m_bvalid,
                      o_s_arvalid, o_s_awvalid, o_s_wvalid, o_s_wlast, o_s_rready,
                      o_s_bready, o_busy, o_gnt_idx};

   axi4_rr_bus_arbiter #(.NMST(4), .IDX_BITS(2)) dut (
      .i_clk       (i_clk),
      .i_nrst      (i_nrst),
      .i_m_arvalid (i_m_arvalid),
      .o_m_arready (o_m_arready),
      .i_m_awvalid (i_m_awvalid),
      .o_m_awready (o_m_awready),
      .i_m_wvalid  (i_m_wvalid),
      .i_m_wlast   (i_m_wlast),
      .o_m_wready  (o_m_wready),
      .o_m_rvalid  (o_m_rvalid),
      .i_m_rready  (i_m_rready),
      .o_m_bvalid  (o_m_bvalid),
      .i_m_bready  (i_m_bready),
      .o_s_arvalid (o_s_arvalid),
      .i_s_arready (i_s_arready),
      .o_s_awvalid (o_s_awvalid),
      .i_s_awready (i_s_awready),
      .o_s_wvalid  (o_s_wvalid),
      .o_s_wlast   (o_s_wlast),
      .i_s_wready  (i_s_wready),
      .i_s_rvalid  (i_s_rvalid),
      .i_s_rlast   (i_s_rlast),
      .o_s_rready  (o_s_rready),
      .i_s_bvalid  (i_s_bvalid),
      .o_s_bready  (o_s_bready),
      .o_gnt_idx   (o_gnt_idx),
      .o_busy      (o_busy)
   );

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   // Completes a read already in AR for master m with a single-beat R.
   task automatic finish_read(input int m, input bit drop);
      i_s_arready = 1'b1;
      cyc();
      if (drop) i_m_arvalid[m] = 1'b0;
      i_s_arready = 1'b0;
      i_s_rvalid  = 1'b1;
      i_s_rlast   = 1'b1;
      i_m_rready[m] = 1'b1;
      cyc();
      i_s_rvalid = 1'b0;
      i_s_rlast  = 1'b0;
      i_m_rready = '0;
   endtask

   task automatic test_reset();
      i_nrst = 1'b0;
      i_m_arvalid = 4'hF; i_m_awvalid = 4'hF; i_m_wvalid = 4'hF; i_m_wlast = 4'hF;
      i_m_rready = 4'hF; i_m_bready = 4'hF;
      i_s_arready = 1; i_s_awready = 1; i_s_wready = 1;
      i_s_rvalid = 1; i_s_rlast = 1; i_s_bvalid = 1;
      cyc(); cyc();
      n_chk++;
      if (all_outs !== 29'd0) begin
         n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs);
      end
      i_m_arvalid = '0; i_m_awvalid = '0; i_m_wvalid = '0; i_m_wlast = '0;
      i_m_rready = '0; i_m_bready = '0;
      i_s_arready = 0; i_s_awready = 0; i_s_wready = 0;
      i_s_rvalid = 0; i_s_rlast = 0; i_s_bvalid = 0;
      cyc();
      i_nrst = 1'b1;
      cyc();
      #1;
      n_chk++;
      if (o_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
      end
   endtask

   task automatic test_single_read();
      i_m_arvalid = 4'b0100;
      cyc();
      #1;
      n_chk++;
      if ({o_s_arvalid, o_gnt_idx, o_busy, o_m_arready} !== {1'b1, 2'd2, 1'b1, 4'b0000}) begin
         n_fail++; $display("FAIL rd_grant: got arv=%b gnt=%0d busy=%b arready=%b expected 1 2 1 0000",
                            o_s_arvalid, o_gnt_idx, o_busy, o_m_arready);
      end
      i_s_arready = 1'b1;
      #1;
      n_chk++;
      if (o_m_arready !== 4'b0100) begin
         n_fail++; $display("FAIL rd_arready: got %b expected 0100", o_m_arready);
      end
      cyc();
      i_m_arvalid = '0; i_s_arready = 1'b0;
      i_s_rvalid = 1'b1; i_m_rready = 4'b0100;
      for (int b = 1; b <= 4; b++) begin
         i_s_rlast = (b == 4);
         #1;
         n_chk++;
         if ({o_m_rvalid, o_s_rready, o_busy} !== {4'b0100, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL rd_beat%0d: got rvalid=%b rready=%b busy=%b expected 0100 1 1",
                               b, o_m_rvalid, o_s_rready, o_busy);
         end
         cyc();
      end
      i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m_rready = '0;
      #1;
      n_chk++;
      if ({o_busy, o_m_rvalid} !== 5'b0) begin
         n_fail++; $display("FAIL rd_done: got busy=%b rvalid=%b expected 0 0000", o_busy, o_m_rvalid);
      end
   endtask

   task automatic test_wrap();
      // Pointer is 3 after the m2 read; only m1 requests.
      i_m_arvalid = 4'b0010;
      cyc();
      n_chk++;
      if (o_gnt_idx !== 2'd1) begin
         n_fail++; $display("FAIL wrap_gnt: got %0d expected 1", o_gnt_idx);
      end
      finish_read(1, 1'b1);
      // Pointer now 2: m0 and m2 both request, m2 must win.
      i_m_arvalid = 4'b0101;
      cyc();
      n_chk++;
      if (o_gnt_idx !== 2'd2) begin
         n_fail++; $display("FAIL wrap_ptr2: got %0d expected 2", o_gnt_idx);
      end
      finish_read(2, 1'b1);
      cyc();
      n_chk++;
      if (o_gnt_idx !== 2'd0) begin
         n_fail++; $display("FAIL wrap_m0: got %0d expected 0", o_gnt_idx);
      end
      finish_read(0, 1'b1);
   endtask

   task automatic test_write();
      // Pointer is 1: m1 writes, W data presented before AW must not be accepted.
      i_m_awvalid = 4'b0010; i_m_wvalid = 4'b0010; i_s_wready = 1'b1;
      cyc();
      n_chk++;
      if ({o_s_awvalid, o_gnt_idx, o_m_wready, o_s_wvalid} !== {1'b1, 2'd1, 4'b0000, 1'b0}) begin
         n_fail++; $display("FAIL wr_aw: got awv=%b gnt=%0d wready=%b wvalid=%b expected 1 1 0000 0",
                            o_s_awvalid, o_gnt_idx, o_m_wready, o_s_wvalid);
      end
      i_s_awready = 1'b1;
      #1;
      n_chk++;
      if (o_m_awready !== 4'b0010) begin
         n_fail++; $display("FAIL wr_awready: got %b expected 0010", o_m_awready);
      end
      cyc();
      i_m_awvalid = '0; i_s_awready = 1'b0; i_s_wready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         n_chk++;
         if ({o_s_wvalid, o_m_wready} !== {1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL wr_stall%0d: got wvalid=%b wready=%b expected 1 0000",
                               s, o_s_wvalid, o_m_wready);
         end
         if (s < 2) cyc();
      end
      i_s_wready = 1'b1;
      #1;
      n_chk++;
      if ({o_m_wready, o_s_wlast} !== {4'b0010, 1'b0}) begin
         n_fail++; $display("FAIL wr_beat1: got wready=%b wlast=%b expected 0010 0", o_m_wready, o_s_wlast);
      end
      cyc();
      i_m_wlast = 4'b0010;
      #1;
      n_chk++;
      if ({o_m_wready, o_s_wlast} !== {4'b0010, 1'b1}) begin
         n_fail++; $display("FAIL wr_beat2: got wready=%b wlast=%b expected 0010 1", o_m_wready, o_s_wlast);
      end
      cyc();
      i_m_wvalid = '0; i_m_wlast = '0; i_s_wready = 1'b0;
      i_s_bvalid = 1'b1; i_m_bready = 4'b1101;
      #1;
      n_chk++;
      if ({o_m_bvalid, o_s_bready} !== {4'b0010, 1'b0}) begin
         n_fail++; $display("FAIL wr_b_stall: got bvalid=%b bready=%b expected 0010 0", o_m_bvalid, o_s_bready);
      end
      cyc();
      i_m_bready = 4'b0010;
      #1;
      n_chk++;
      if ({o_m_bvalid, o_s_bready} !== {4'b0010, 1'b1}) begin
         n_fail++; $display("FAIL wr_b: got bvalid=%b bready=%b expected 0010 1", o_m_bvalid, o_s_bready);
      end
      cyc();
      i_s_bvalid = 1'b0; i_m_bready = '0;
      #1;
      n_chk++;
      if ({o_busy, o_m_bvalid} !== 5'b0) begin
         n_fail++; $display("FAIL wr_done: got busy=%b bvalid=%b expected 0 0000", o_busy, o_m_bvalid);
      end
   endtask

   task automatic test_reset_mid_w();
      // Pointer is 2: m2 starts a write, reset lands after its first W beat.
      i_m_awvalid = 4'b0100; i_m_wvalid = 4'b0100;
      cyc();
      i_s_awready = 1'b1;
      cyc();
      i_m_awvalid = '0; i_s_awready = 1'b0; i_s_wready = 1'b1;
      cyc();
      n_chk++;
      if ({o_s_wvalid, o_busy, o_gnt_idx} !== {1'b1, 1'b1, 2'd2}) begin
         n_fail++; $display("FAIL rstw_inburst: got wvalid=%b busy=%b gnt=%0d expected 1 1 2",
                            o_s_wvalid, o_busy, o_gnt_idx);
      end
      i_nrst = 1'b0;
      i_m_arvalid = 4'hF;
      cyc(); cyc();
      n_chk++;
      if (all_outs !== 29'd0) begin
         n_fail++; $display("FAIL rstw_outs: got %h expected 0", all_outs);
      end
      i_nrst = 1'b1; i_m_wvalid = '0; i_s_wready = 1'b0;
      cyc();
      n_chk++;
      if ({o_gnt_idx, o_s_arvalid} !== {2'd0, 1'b1}) begin
         n_fail++; $display("FAIL rstw_next_m0: got gnt=%0d arv=%b expected 0 1", o_gnt_idx, o_s_arvalid);
      end
   endtask

   task automatic test_fairness();
      // All masters hold arvalid; already in AR for m0 after the reset.
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if (o_gnt_idx !== 2'(k % 4)) begin
            n_fail++; $display("FAIL fair_order%0d: got %0d expected %0d", k, o_gnt_idx, k % 4);
         end
         i_s_arready = 1'b1;
         #1;
         n_chk++;
         if (o_m_arready !== (4'b0001 << (k % 4))) begin
            n_fail++; $display("FAIL fair_arready%0d: got %b expected %b", k, o_m_arready, 4'b0001 << (k % 4));
         end
         cyc();
         i_s_arready = 1'b0; i_s_rvalid = 1'b1; i_s_rlast = 1'b1; i_m_rready = 4'hF;
         cyc();
         i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_m_rready = '0;
         if (k < 4) cyc();
      end
      i_m_arvalid = '0;
   endtask

   task automatic test_aw_ar_same();
      // Pointer is 1: m0 presents AW and AR together.
      i_m_awvalid = 4'b0001; i_m_arvalid = 4'b0001; i_m_wvalid = 4'b0001; i_m_wlast = 4'b0001;
      cyc();
      n_chk++;
      if ({o_s_awvalid, o_s_arvalid, o_gnt_idx} !== {1'b1, 1'b0, 2'd0}) begin
         n_fail++; $display("FAIL awar_aw_first: got awv=%b arv=%b gnt=%0d expected 1 0 0",
                            o_s_awvalid, o_s_arvalid, o_gnt_idx);
      end
      i_s_awready = 1'b1;
      cyc();
      i_m_awvalid = '0; i_s_awready = 1'b0; i_s_wready = 1'b1;
      cyc();
      i_m_wvalid = '0; i_m_wlast = '0; i_s_wready = 1'b0; i_s_bvalid = 1'b1; i_m_bready = 4'b0001;
      cyc();
      i_s_bvalid = 1'b0; i_m_bready = '0;
      #1;
      n_chk++;
      if (o_busy !== 1'b0) begin
         n_fail++; $display("FAIL awar_idle_gap: got busy=%b expected 0", o_busy);
      end
      cyc();
      n_chk++;
      if ({o_s_arvalid, o_s_awvalid, o_gnt_idx} !== {1'b1, 1'b0, 2'd0}) begin
         n_fail++; $display("FAIL awar_ar_next: got arv=%b awv=%b gnt=%0d expected 1 0 0",
                            o_s_arvalid, o_s_awvalid, o_gnt_idx);
      end
      finish_read(0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_wrap();
      test_write();
      test_reset_mid_w();
      test_fairness();
      test_aw_ar_same();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
